// File: rtl/loop_buf_pkg.sv
// -----------------------------------------------------------------------------
// loop_buf_pkg
// Constants and types shared by the stream loop buffer blocks (loop detector,
// uop cache controller).
//   LB_DEPTH / LB_AW / LB_DW : default uop cache geometry
//   lb_state_e               : controller state encoding (also driven on the
//                              controller's debug state output)
//   OPC_*                    : RV32 control-transfer opcodes used by the loop
//                              detector to recognise a loop-closing branch
// -----------------------------------------------------------------------------
package loop_buf_pkg;

    localparam int LB_DEPTH = 64;
    localparam int LB_AW    = 6;
    localparam int LB_DW    = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FILL   = 2'b01,
        ST_LOADED = 2'b10,
        ST_REPLAY = 2'b11
    } lb_state_e;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // True for any control-transfer opcode that can close a loop body.
    function automatic logic is_ctrl_xfer(input logic [6:0] opc);
        return (opc == OPC_JAL) || (opc == OPC_BRANCH) || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/uop_cache_ctrl_if.sv
// -----------------------------------------------------------------------------
// uop_cache_ctrl_if
// Bundle of every handshake/bus signal around uop_cache_ctrl.
//   fill_*   : fill stream from the loop detector (valid/ready)
//   replay_* : replay stream to the IF stage (request / registered valid)
//   abort    : mispredict flush
//   status   : overflow pulse, loop_len, iter_count, state (debug)
//   bram_*   : single write port + single read port of the uop_cache BRAM
// Handshake rule: a fill beat transfers on a cycle where fill_valid and
// fill_ready are both high; fill_ready never depends on fill_valid. A replay
// read is issued on each cycle replay_req is high while a body is loaded, and
// replay_valid marks the returned instruction exactly one cycle later.
// Modports: slave = controller side, master = environment side.
// -----------------------------------------------------------------------------
interface uop_cache_ctrl_if
    import loop_buf_pkg::*;
#(
    parameter int AW = LB_AW,
    parameter int DW = LB_DW
);
    logic          fill_valid;
    logic [DW-1:0] fill_data;
    logic          fill_last;
    logic          fill_ready;
    logic          replay_req;
    logic          replay_valid;
    logic [DW-1:0] replay_data;
    logic          replay_last;
    logic          abort;
    logic          overflow;
    logic [AW:0]   loop_len;
    logic [15:0]   iter_count;
    logic [1:0]    state;
    logic          bram_we;
    logic [AW-1:0] bram_waddr;
    logic [DW-1:0] bram_wdata;
    logic          bram_re;
    logic [AW-1:0] bram_raddr;
    logic [DW-1:0] bram_rdata;

    modport slave (
        input  fill_valid, fill_data, fill_last, replay_req, abort, bram_rdata,
        output fill_ready, replay_valid, replay_data, replay_last, overflow,
               loop_len, iter_count, state, bram_we, bram_waddr, bram_wdata,
               bram_re, bram_raddr
    );

    modport master (
        output fill_valid, fill_data, fill_last, replay_req, abort, bram_rdata,
        input  fill_ready, replay_valid, replay_data, replay_last, overflow,
               loop_len, iter_count, state, bram_we, bram_waddr, bram_wdata,
               bram_re, bram_raddr
    );
endinterface

// File: rtl/wrap_ptr.sv
// -----------------------------------------------------------------------------
// wrap_ptr
// AW-bit address counter that wraps to 0 after reaching a programmable limit.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_clear        : synchronous clear to 0 (wins over i_inc)
//   i_inc          : advance by one, wrapping from i_limit to 0
//   i_limit        : last address before wrap
//   o_ptr          : current pointer value
// -----------------------------------------------------------------------------
module wrap_ptr
    import loop_buf_pkg::*;
#(
    parameter int AW = LB_AW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic          i_inc,
    input  logic [AW-1:0] i_limit,
    output logic [AW-1:0] o_ptr
);
    logic [AW-1:0] r_ptr;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (i_clear) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= (r_ptr == i_limit) ? '0 : r_ptr + AW'(1);
        end
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/uop_cache_ctrl.sv
// -----------------------------------------------------------------------------
// uop_cache_ctrl
// Sequencing controller for the loop-buffer uop cache BRAM. Stores a fill
// stream of loop-body instructions, commits the body length on the
// loop-closing beat, replays the body with wrap-around on fetch demand and
// discards everything on abort.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : uop_cache_ctrl_if.slave (fill, replay, abort, status, BRAM)
// -----------------------------------------------------------------------------
module uop_cache_ctrl
    import loop_buf_pkg::*;
#(
    parameter int DEPTH = LB_DEPTH,
    parameter int AW    = LB_AW,
    parameter int DW    = LB_DW
) (
    input  logic             clk,
    input  logic             reset,
    uop_cache_ctrl_if.slave  bus
);
    localparam logic [AW-1:0] WPTR_LAST = AW'(DEPTH - 1);

    lb_state_e     r_state;
    logic [AW:0]   r_loop_len;
    logic          r_overflow;
    logic          r_replay_valid;
    logic          r_replay_last;
    logic [15:0]   r_iter_count;

    logic [AW-1:0] w_wptr;
    logic [AW-1:0] w_rptr;
    logic [AW-1:0] w_rlimit;
    logic [AW:0]   w_len_p1;
    logic [DW-1:0] w_fill_data;
    logic          w_fill_ready;
    logic          w_fill_xfer;
    logic          w_commit;
    logic          w_ovf;
    logic          w_read;

    assign w_fill_data  = bus.fill_data;
    // Abort masks ready, so a beat arriving with abort never writes or commits.
    assign w_fill_ready = ((r_state == ST_IDLE) || (r_state == ST_FILL)) && !bus.abort;
    assign w_fill_xfer  = bus.fill_valid && w_fill_ready;
    assign w_commit     = w_fill_xfer && bus.fill_last;
    // The DEPTH-th beat without fill_last means the body cannot fit.
    assign w_ovf        = w_fill_xfer && !bus.fill_last && (r_state == ST_FILL)
                          && (w_wptr == WPTR_LAST);
    assign w_read       = ((r_state == ST_LOADED) || (r_state == ST_REPLAY))
                          && bus.replay_req && !bus.abort;
    // loop_len of DEPTH truncates to 0 here, so the limit correctly becomes DEPTH-1.
    assign w_rlimit     = r_loop_len[AW-1:0] - AW'(1);
    assign w_len_p1     = {1'b0, w_wptr} + (AW+1)'(1);

    wrap_ptr #(.AW(AW)) u_wptr (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clear (bus.abort || w_commit || w_ovf),
        .i_inc   (w_fill_xfer),
        .i_limit (WPTR_LAST),
        .o_ptr   (w_wptr)
    );

    // rptr only moves in LOADED/REPLAY and is zero on entry to LOADED, since
    // the only exits from REPLAY are abort and reset, both of which clear it.
    wrap_ptr #(.AW(AW)) u_rptr (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clear (bus.abort),
        .i_inc   (w_read),
        .i_limit (w_rlimit),
        .o_ptr   (w_rptr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_loop_len     <= '0;
            r_overflow     <= 1'b0;
            r_replay_valid <= 1'b0;
            r_replay_last  <= 1'b0;
            r_iter_count   <= '0;
        end else begin
            r_overflow     <= w_ovf;
            r_replay_valid <= w_read;
            r_replay_last  <= w_read && (w_rptr == w_rlimit);

            if (bus.abort) begin
                r_iter_count <= '0;
            end else if (r_replay_valid && r_replay_last && (r_iter_count != 16'hFFFF)) begin
                r_iter_count <= r_iter_count + 16'd1;
            end

            if (bus.abort) begin
                r_state    <= ST_IDLE;
                r_loop_len <= '0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_FILL: begin
                        if (w_commit) begin
                            r_loop_len <= w_len_p1;
                            r_state    <= ST_LOADED;
                        end else if (w_ovf) begin
                            r_loop_len <= '0;
                            r_state    <= ST_IDLE;
                        end else if (w_fill_xfer) begin
                            r_state    <= ST_FILL;
                        end
                    end
                    ST_LOADED: begin
                        if (w_read) begin
                            r_state <= ST_REPLAY;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign bus.fill_ready   = w_fill_ready;
    assign bus.bram_we      = w_fill_xfer;
    assign bus.bram_waddr   = w_wptr;
    assign bus.bram_wdata   = w_fill_data;
    assign bus.bram_re      = w_read;
    assign bus.bram_raddr   = w_rptr;
    assign bus.replay_valid = r_replay_valid;
    assign bus.replay_last  = r_replay_last;
    assign bus.replay_data  = bus.bram_rdata;
    assign bus.overflow     = r_overflow;
    assign bus.loop_len     = r_loop_len;
    assign bus.iter_count   = r_iter_count;
    assign bus.state        = r_state;
endmodule

// File: tb/tb_uop_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uop_cache_ctrl
// Directed scenarios with random instruction data and a random soak phase.
// A behavioural reference model (body array, read counter modulo loop length,
// expected-data queue) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_uop_cache_ctrl;
    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic clk;
    logic reset;

    uop_cache_ctrl_if #(.AW(AW), .DW(DW)) bus();

    uop_cache_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- BRAM stand-in ----------------
    logic [DW-1:0] bram [DEPTH];
    always @(posedge clk) begin
        if (bus.bram_we) bram[bus.bram_waddr] <= bus.bram_wdata;
        if (bus.bram_re) bus.bram_rdata <= bram[bus.bram_raddr];
    end

    // ---------------- scoreboard / model ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    int            m_st;     // 0 IDLE, 1 FILL, 2 LOADED, 3 REPLAY
    int            m_len;
    int            m_wcnt;   // beats stored of the body being filled
    int            m_reads;  // reads issued since the body was committed
    int            m_iter;
    bit            m_rv;
    bit            m_rlast;
    bit            m_ovf;
    logic [DW-1:0] body [DEPTH];
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_len = 0; m_wcnt = 0; m_reads = 0; m_iter = 0;
        m_rv = 0; m_rlast = 0; m_ovf = 0;
        exp_q.delete();
    endtask

    task automatic drive_idle();
        bus.fill_valid = 1'b0;
        bus.fill_data  = '0;
        bus.fill_last  = 1'b0;
        bus.replay_req = 1'b0;
        bus.abort      = 1'b0;
    endtask

    // Called at posedge+1 with inputs applied: checks this cycle, then
    // advances the model across the next edge.
    task automatic tick();
        bit            e_ready, e_xfer, e_re;
        int            e_raddr, n_iter;
        bit            c_fl, c_ab;
        logic [DW-1:0] c_fd, q_data;
        #1;
        c_fl    = bus.fill_last;
        c_ab    = bus.abort;
        c_fd    = bus.fill_data;
        e_ready = ((m_st == 0) || (m_st == 1)) && !c_ab;
        e_xfer  = bus.fill_valid && e_ready;
        e_re    = (m_st >= 2) && bus.replay_req && !c_ab;
        e_raddr = (m_len > 0) ? (m_reads % m_len) : 0;

        chk("fill_ready", bus.fill_ready, e_ready);
        chk("bram_we", bus.bram_we, e_xfer);
        if (e_xfer) begin
            chk("bram_waddr", bus.bram_waddr, m_wcnt);
            chk("bram_wdata", bus.bram_wdata, c_fd);
        end
        chk("bram_re", bus.bram_re, e_re);
        if (e_re) chk("bram_raddr", bus.bram_raddr, e_raddr);
        chk("state", bus.state, m_st);
        chk("loop_len", bus.loop_len, m_len);
        chk("iter_count", bus.iter_count, m_iter);
        chk("overflow", bus.overflow, m_ovf);
        chk("replay_valid", bus.replay_valid, m_rv);
        if (m_rv) begin
            q_data = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            chk("replay_last", bus.replay_last, m_rlast);
            chk("replay_data", bus.replay_data, q_data);
        end

        @(posedge clk);
        n_iter = m_iter;
        if (c_ab) n_iter = 0;
        else if (m_rv && m_rlast && (m_iter != 65535)) n_iter = m_iter + 1;
        m_iter  = n_iter;
        m_rv    = e_re;
        m_rlast = e_re && (e_raddr == m_len - 1);
        if (e_re) exp_q.push_back(body[e_raddr]);
        m_ovf = 0;
        if (c_ab) begin
            m_st = 0; m_len = 0; m_wcnt = 0; m_reads = 0;
        end else if (e_xfer) begin
            body[m_wcnt] = c_fd;
            if (c_fl) begin
                m_len = m_wcnt + 1; m_st = 2; m_wcnt = 0; m_reads = 0;
            end else if (m_wcnt == DEPTH - 1) begin
                m_ovf = 1; m_st = 0; m_len = 0; m_wcnt = 0;
            end else begin
                m_wcnt++; m_st = 1;
            end
        end else if (e_re) begin
            m_reads++; m_st = 3;
        end
        #1;
    endtask

    task automatic fill_body(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            bus.fill_valid = 1'b1;
            bus.fill_data  = $urandom;
            bus.fill_last  = with_last && (i == n - 1);
            tick();
        end
        bus.fill_valid = 1'b0;
        bus.fill_last  = 1'b0;
    endtask

    task automatic replay(input int n);
        bus.replay_req = 1'b1;
        repeat (n) tick();
        bus.replay_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        drive_idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_state", bus.state, 2'b00);
        chk("rst_loop_len", bus.loop_len, 0);
        chk("rst_iter", bus.iter_count, 0);
        chk("rst_rvalid", bus.replay_valid, 0);
        chk("rst_rlast", bus.replay_last, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_ready", bus.fill_ready, 1);
        chk("rst_we", bus.bram_we, 0);
        chk("rst_re", bus.bram_re, 0);
        model_reset();
        reset = 1'b0;
        tick();

        // 5-beat body, 12 replay cycles, two full iterations
        fill_body(5, 1'b1);
        chk("len5", bus.loop_len, 5);
        chk("loaded", bus.state, 2'b10);
        replay(12);
        tick();
        tick();
        chk("iter2", bus.iter_count, 2);
        // replay_req dropped at rptr=2 for three cycles, then resumed
        tick();
        bus.replay_req = 1'b1;
        #1;
        chk("resume_addr", bus.bram_raddr, 2);
        replay(5);

        // abort with a read in flight, then an immediate new fill
        bus.replay_req = 1'b1;
        bus.abort      = 1'b1;
        tick();
        bus.replay_req = 1'b0;
        bus.abort      = 1'b0;
        bus.fill_valid = 1'b1;
        bus.fill_data  = $urandom;
        #1;
        chk("abort_rvalid", bus.replay_valid, 0);
        chk("abort_iter", bus.iter_count, 0);
        chk("refill_ready", bus.fill_ready, 1);
        tick();
        bus.fill_data = $urandom;
        tick();
        // abort beats fill_last on beat 3
        bus.fill_data = $urandom;
        bus.fill_last = 1'b1;
        bus.abort     = 1'b1;
        #1;
        chk("abort_last_we", bus.bram_we, 0);
        tick();
        drive_idle();
        chk("abort_last_state", bus.state, 2'b00);
        chk("abort_last_len", bus.loop_len, 0);
        tick();

        // full-depth body is legal
        fill_body(DEPTH, 1'b1);
        chk("len64", bus.loop_len, 64);
        chk("len64_no_ovf", bus.overflow, 0);
        replay(70);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;

        // 65 beats without last overflow after beat 64
        fill_body(DEPTH, 1'b0);
        chk("ovf_pulse", bus.overflow, 1);
        chk("ovf_state", bus.state, 2'b00);
        chk("ovf_len", bus.loop_len, 0);
        fill_body(1, 1'b0);
        chk("ovf_pulse_end", bus.overflow, 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;

        // single-instruction body, then reset mid-replay
        fill_body(1, 1'b1);
        chk("len1", bus.loop_len, 1);
        replay(3);
        bus.replay_req = 1'b1;
        replay(4);
        bus.replay_req = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_state", bus.state, 2'b00);
        chk("mid_rst_len", bus.loop_len, 0);
        chk("mid_rst_iter", bus.iter_count, 0);
        chk("mid_rst_rvalid", bus.replay_valid, 0);
        chk("mid_rst_rlast", bus.replay_last, 0);
        chk("mid_rst_ovf", bus.overflow, 0);
        chk("mid_rst_ready", bus.fill_ready, 1);
        chk("mid_rst_we", bus.bram_we, 0);
        chk("mid_rst_re", bus.bram_re, 0);
        drive_idle();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // random soak
        for (int c = 0; c < 800; c++) begin
            bus.fill_valid = ($urandom_range(0, 3) != 0);
            bus.fill_data  = $urandom;
            bus.fill_last  = ($urandom_range(0, 5) == 0);
            bus.replay_req = ($urandom_range(0, 3) != 0);
            bus.abort      = ($urandom_range(0, 40) == 0);
            tick();
        end
        drive_idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uop_cache_ctrl.md
# uop_cache_ctrl

Sequencing controller for the 64-entry uop cache BRAM used by the stream loop buffer. It owns the BRAM's single write port and single read port, and accepts a fill stream of loop-body instructions, committing the loop length on the loop-closing branch. On demand from fetch it replays the stored body with wrap-around, and discards everything on abort (mispredict). It sits between the loop detector FSM (fill/abort), the IF stage (replay), and the `uop_cache` instance.

## Interface
- `DEPTH`, 64, number of BRAM entries.
- `AW`, 6, BRAM address width; `DEPTH` = 2^`AW`.
- `DW`, 32, instruction width.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `fill_valid` in 1: fill instruction present.
- `fill_data` in `DW`: instruction to store.
- `fill_last` in 1: this fill beat is the loop-closing branch.
- `fill_ready` out 1: controller accepts a fill beat this cycle.
- `replay_req` in 1: fetch requests the next replayed instruction.
- `replay_valid` out 1: `replay_data` valid.
- `replay_data` out `DW`: replayed instruction.
- `replay_last` out 1: `replay_data` is the loop-closing branch.
- `abort` in 1: mispredict/flush; discard the buffer.
- `overflow` out 1: one-cycle pulse when the body exceeds `DEPTH`.
- `loop_len` out `AW`+1: committed body length, 0 when empty.
- `iter_count` out 16: completed replay iterations, saturating.
- `state` out 2: IDLE=00, FILL=01, LOADED=10, REPLAY=11.
- `bram_we` out 1, `bram_waddr` out `AW`, `bram_wdata` out `DW`: write port.
- `bram_re` out 1, `bram_raddr` out `AW`: read port.
- `bram_rdata` in `DW`: read data, valid one cycle after `bram_re`.

## Operation
- Fill handshake: a beat transfers on `fill_valid & fill_ready`. `fill_ready` = (state IDLE or FILL) & !`abort`.
- Write port on a transfer:
  - `bram_we` = 1, `bram_waddr` = wptr, `bram_wdata` = `fill_data`, all combinational.
  - wptr increments.
- IDLE: wptr = 0. A transfer moves to FILL. A transfer with `fill_last` commits `loop_len` = 1 and moves to LOADED.
- FILL:
  - A transfer with `fill_last` commits `loop_len` = wptr+1 and moves to LOADED.
  - A transfer at wptr = `DEPTH`-1 without `fill_last` pulses `overflow`, sets `loop_len` = 0, and returns to IDLE.
  - A body of exactly `DEPTH` beats ending with `fill_last` is legal.
- LOADED: `fill_ready` = 0. `replay_req` issues a read at address 0 and moves to REPLAY.
- REPLAY:
  - Each cycle with `replay_req` = 1: `bram_re` = 1 and `bram_raddr` = rptr.
  - rptr advances, wrapping from `loop_len`-1 to 0. `loop_len` = 1 re-reads address 0 every cycle.
  - `replay_req` = 0: rptr holds and no read is issued.
- Read pipeline:
  - `replay_valid` is `bram_re` registered, cleared by `abort`.
  - `replay_last` is registered (raddr == `loop_len`-1) & `bram_re`.
  - `replay_data` = `bram_rdata`.
- `iter_count` increments when `replay_valid & replay_last`, saturates at 16'hFFFF, and clears on `abort`.
- `abort` in any state:
  - Next state IDLE; wptr, rptr, `loop_len` and `iter_count` cleared.
  - Same-cycle `bram_we`/`bram_re` forced 0, so `abort` beats a simultaneous `fill_last` and nothing is committed.
  - `replay_valid` is 0 in the cycle after `abort`.
- `abort` in IDLE: no effect beyond holding the pointers at 0.

## Timing
- Reset values: state IDLE, wptr = rptr = 0, `loop_len` = 0, `iter_count` = 0, `replay_valid` = `replay_last` = `overflow` = 0, `fill_ready` = 1, `bram_we` = `bram_re` = 0.
- Fill: 1 beat per cycle with no bubbles. The BRAM write occurs on the same edge as the transfer.
- LOADED is entered on the edge after the last transfer, so the first `replay_req` is honoured one cycle later at the earliest.
- Replay latency: `replay_valid` is 1 cycle after `bram_re`. Sustained throughput is 1 per cycle.
- `overflow` is high for exactly the cycle after the offending edge.
- `reset` mid-operation clears everything asynchronously. No partial body survives.

## Structure
- Shared package `loop_buf_pkg`:
  - State encoding constants.
  - `DEPTH`/`AW` defaults.
  - JAL/B-type/JALR opcode constants, shared with the loop detector.
- Sub-module `wrap_ptr`: `AW`-bit counter with inc, clear and programmable wrap limit. It is used for rptr; wptr uses it with the limit at `DEPTH`-1.
- The BRAM itself stays outside; `uop_cache` is instantiated by the parent.

## Test plan
- Fill 5 beats (last on the 5th), then hold `replay_req` for 12 cycles. Required response:
  - `loop_len` = 5.
  - Read addresses 0,1,2,3,4,0,1,…
  - `replay_last` on every 5th valid.
  - `iter_count` = 2 after 10 valid beats.
- Fill 64 beats with `fill_last` on beat 64 → `loop_len` = 64 and no `overflow`. Fill 65 beats without last → `overflow` pulse after beat 64, state IDLE, `loop_len` = 0.
- `abort` asserted together with `fill_last` on beat 3 → `bram_we` = 0 that cycle, state IDLE, `loop_len` = 0.
- Drop `replay_req` mid-loop at rptr = 2 for 3 cycles → no reads and `replay_valid` = 0. Resume at address 2.
- `abort` during REPLAY with a read in flight → `replay_valid` = 0 next cycle and `iter_count` = 0. A new fill is accepted immediately.
- `loop_len` = 1 → continuous reads of address 0, `replay_last` on every valid beat. Assert `reset` mid-replay → all outputs at their reset values.
